// File: rtl/sdrstick_tx_feeder.sv
// Transmit sample feeder: pops I/Q word pairs from the TX FIFO once per sample
// period and presents them as 16-bit samples with a tx_valid strobe.
module sdrstick_tx_feeder (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fifo_readdata,
  input  logic [10:0] fifo_level,
  output logic        fifo_read,
  input  logic [2:0]  ctl_address,
  input  logic        ctl_read,
  output logic [31:0] ctl_readdata,
  input  logic        ctl_write,
  input  logic [31:0] ctl_writedata,
  output logic [15:0] tx_i,
  output logic [15:0] tx_q,
  output logic        tx_valid,
  output logic        underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RD_Q, S_CAP_I, S_CAP_Q, S_OUT
  } state_t;

  state_t      state, state_n;
  logic        enable;
  logic [15:0] period;
  logic [15:0] eff_period;
  logic [15:0] cnt;
  logic        tick;
  logic [31:0] underruns;
  logic [31:0] samples;
  logic        uflag, uflag_n;
  logic        fifo_read_n, underrun_n, tx_valid_n;
  logic [15:0] cap_i, cap_q;
  logic        busy;
  logic        ctrl_wr, clr_underruns;

  assign eff_period    = (period < 16'd8) ? 16'd8 : period;
  assign tick          = enable && (cnt == 16'd0);
  assign busy          = (state != S_IDLE) && (state != S_WAIT);
  assign ctrl_wr       = ctl_write && (ctl_address == 3'd0);
  assign clr_underruns = ctrl_wr && ctl_writedata[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 16'd639;
    end else if (!enable || cnt == 16'd0) begin
      cnt <= eff_period - 16'd1;
    end else begin
      cnt <= cnt - 16'd1;
    end
  end

  always_comb begin
    state_n     = state;
    fifo_read_n = 1'b0;
    underrun_n  = 1'b0;
    tx_valid_n  = 1'b0;
    uflag_n     = uflag;
    case (state)
      S_IDLE: if (enable) state_n = S_WAIT;
      S_WAIT: begin
        if (!enable) begin
          state_n = S_IDLE;
        end else if (tick) begin
          state_n = S_RD_Q;
          if (fifo_level >= 11'd2) begin
            fifo_read_n = 1'b1;
            uflag_n     = 1'b0;
          end else begin
            uflag_n    = 1'b1;
            underrun_n = 1'b1;
          end
        end
      end
      S_RD_Q: begin
        fifo_read_n = !uflag;
        state_n     = S_CAP_I;
      end
      S_CAP_I: state_n = S_CAP_Q;
      S_CAP_Q: state_n = S_OUT;
      S_OUT: begin
        tx_valid_n = 1'b1;
        state_n    = enable ? S_WAIT : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      fifo_read <= 1'b0;
      underrun  <= 1'b0;
      tx_valid  <= 1'b0;
      uflag     <= 1'b0;
      cap_i     <= 16'd0;
      cap_q     <= 16'd0;
      tx_i      <= 16'd0;
      tx_q      <= 16'd0;
      samples   <= 32'd0;
    end else begin
      state     <= state_n;
      fifo_read <= fifo_read_n;
      underrun  <= underrun_n;
      tx_valid  <= tx_valid_n;
      uflag     <= uflag_n;
      // FIFO data arrives one cycle after each pop, so I lands in CAP_I and Q in CAP_Q
      if (state == S_CAP_I) cap_i <= uflag ? 16'd0 : fifo_readdata[23:8];
      if (state == S_CAP_Q) cap_q <= uflag ? 16'd0 : fifo_readdata[23:8];
      if (state == S_OUT) begin
        tx_i <= cap_i;
        tx_q <= cap_q;
        if (!uflag) samples <= samples + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable       <= 1'b0;
      period       <= 16'd640;
      underruns    <= 32'd0;
      ctl_readdata <= 32'd0;
    end else begin
      if (ctrl_wr) enable <= ctl_writedata[0];
      if (ctl_write && ctl_address == 3'd1) period <= ctl_writedata[15:0];
      // a clear landing on the same cycle as an underrun leaves the count at zero
      if (clr_underruns) begin
        underruns <= 32'd0;
      end else if (underrun_n && underruns != 32'hFFFF_FFFF) begin
        underruns <= underruns + 32'd1;
      end
      if (ctl_read && !ctl_write) begin
        case (ctl_address)
          3'd0:    ctl_readdata <= {31'd0, enable};
          3'd1:    ctl_readdata <= {16'd0, period};
          3'd2:    ctl_readdata <= underruns;
          3'd3:    ctl_readdata <= samples;
          3'd4:    ctl_readdata <= {31'd0, busy};
          default: ctl_readdata <= 32'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdrstick_tx_feeder.sv
// Directed bench for sdrstick_tx_feeder with a behavioural TX FIFO and an
// event monitor that timestamps pops, strobes and underruns.
module tb_sdrstick_tx_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fifo_readdata = 32'd0;
  logic [10:0] fifo_level;
  logic        fifo_read;
  logic [2:0]  ctl_address = 3'd0;
  logic        ctl_read = 1'b0;
  logic [31:0] ctl_readdata;
  logic        ctl_write = 1'b0;
  logic [31:0] ctl_writedata = 32'd0;
  logic [15:0] tx_i, tx_q;
  logic        tx_valid, underrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] mem [1024];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        flush = 1'b0;

  int          pop_cyc [1024];
  int          txv_cyc [1024];
  logic [15:0] txv_i [1024];
  logic [15:0] txv_q [1024];
  int          und_cyc [1024];
  int          n_pop = 0, n_txv = 0, n_und = 0;

  sdrstick_tx_feeder dut (
    .clk(clk), .reset(reset),
    .fifo_readdata(fifo_readdata), .fifo_level(fifo_level), .fifo_read(fifo_read),
    .ctl_address(ctl_address), .ctl_read(ctl_read), .ctl_readdata(ctl_readdata),
    .ctl_write(ctl_write), .ctl_writedata(ctl_writedata),
    .tx_i(tx_i), .tx_q(tx_q), .tx_valid(tx_valid), .underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign fifo_level = 11'(wr_ptr - rd_ptr);

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_read) begin
      fifo_readdata <= mem[rd_ptr % 1024];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (fifo_read) begin
      pop_cyc[n_pop] <= cyc;
      n_pop          <= n_pop + 1;
    end
    if (tx_valid) begin
      txv_cyc[n_txv] <= cyc;
      txv_i[n_txv]   <= tx_i;
      txv_q[n_txv]   <= tx_q;
      n_txv          <= n_txv + 1;
    end
    if (underrun) begin
      und_cyc[n_und] <= cyc;
      n_und          <= n_und + 1;
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    ctl_address = a; ctl_writedata = d; ctl_write = 1'b1;
    @(negedge clk);
    ctl_write = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    ctl_address = a; ctl_read = 1'b1;
    @(negedge clk);
    ctl_read = 1'b0;
    d = ctl_readdata;
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr % 1024] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic flush_fifo();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge clk);
    checks++;
    if ({fifo_read, tx_valid, underrun} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes got %b want 000", {fifo_read, tx_valid, underrun});
    end
    checks++;
    if ({tx_i, tx_q, ctl_readdata} !== 64'd0) begin
      errors++; $display("FAIL reset_data got %h %h %h want 0", tx_i, tx_q, ctl_readdata);
    end
    reset = 1'b0;
    @(negedge clk);
    reg_read(3'd1, d);
    checks++; if (d !== 32'd640) begin errors++; $display("FAIL reset_period got %0d want 640", d); end
    reg_read(3'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_ctrl got %h want 0", d); end
    reg_read(3'd2, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_underruns got %0d want 0", d); end
    reg_read(3'd3, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_samples got %0d want 0", d); end
    reg_read(3'd4, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_status got %0d want 0", d); end
  endtask

  task automatic test_basic_pair();
    int w, bp, bt;
    logic [31:0] d;
    apply_reset(); flush_fifo();
    reg_write(3'd1, 32'd8);
    push(32'h0012_3456); push(32'h00FE_DCBA);
    bp = n_pop; bt = n_txv; w = cyc;
    reg_write(3'd0, 32'd1);
    wait_cyc(w + 14);
    reg_write(3'd0, 32'd0);
    wait_cyc(w + 30);
    checks++; if (n_pop - bp !== 2) begin errors++; $display("FAIL basic_pops got %0d want 2", n_pop - bp); end
    checks++; if (pop_cyc[bp] !== w + 9) begin errors++; $display("FAIL basic_pop0_cyc got %0d want %0d", pop_cyc[bp], w + 9); end
    checks++; if (pop_cyc[bp+1] !== w + 10) begin errors++; $display("FAIL basic_pop1_cyc got %0d want %0d", pop_cyc[bp+1], w + 10); end
    checks++; if (n_txv - bt !== 1) begin errors++; $display("FAIL basic_txv_count got %0d want 1", n_txv - bt); end
    checks++; if (txv_cyc[bt] !== w + 13) begin errors++; $display("FAIL basic_txv_cyc got %0d want %0d", txv_cyc[bt], w + 13); end
    checks++; if (txv_i[bt] !== 16'h1234) begin errors++; $display("FAIL basic_tx_i got %h want 1234", txv_i[bt]); end
    checks++; if (txv_q[bt] !== 16'hFEDC) begin errors++; $display("FAIL basic_tx_q got %h want fedc", txv_q[bt]); end
    checks++; if (tx_i !== 16'h1234) begin errors++; $display("FAIL basic_tx_i_hold got %h want 1234", tx_i); end
    reg_read(3'd3, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL basic_samples got %0d want 1", d); end
  endtask

  task automatic test_streaming();
    int w, bp, bt, bu, bad_cyc, bad_val;
    logic [15:0] iv, qv;
    logic [31:0] d;
    apply_reset(); flush_fifo();
    reg_write(3'd1, 32'd10);
    for (int k = 0; k < 200; k++) begin
      iv = 16'(k * 257 + 3);
      qv = 16'(16'hFFFF - k * 3);
      push({8'h00, iv, 8'hAA});
      push({8'hFF, qv, 8'h11});
    end
    bp = n_pop; bt = n_txv; bu = n_und; w = cyc;
    reg_write(3'd0, 32'd1);
    wait_cyc(w + 2006);
    reg_write(3'd0, 32'd0);
    wait_cyc(w + 2030);
    checks++; if (n_txv - bt !== 200) begin errors++; $display("FAIL stream_txv_count got %0d want 200", n_txv - bt); end
    checks++; if (n_pop - bp !== 400) begin errors++; $display("FAIL stream_pops got %0d want 400", n_pop - bp); end
    checks++; if (n_und - bu !== 0) begin errors++; $display("FAIL stream_underruns got %0d want 0", n_und - bu); end
    bad_cyc = 0; bad_val = 0;
    for (int k = 0; k < 200; k++) begin
      iv = 16'(k * 257 + 3);
      qv = 16'(16'hFFFF - k * 3);
      checks++;
      if (txv_cyc[bt+k] !== w + 15 + 10 * k) begin
        errors++; bad_cyc++;
        if (bad_cyc < 4) $display("FAIL stream_cyc[%0d] got %0d want %0d", k, txv_cyc[bt+k], w + 15 + 10 * k);
      end
      checks++;
      if ({txv_i[bt+k], txv_q[bt+k]} !== {iv, qv}) begin
        errors++; bad_val++;
        if (bad_val < 4) $display("FAIL stream_val[%0d] got %h %h want %h %h", k, txv_i[bt+k], txv_q[bt+k], iv, qv);
      end
    end
    reg_read(3'd3, d);
    checks++; if (d !== 32'd200) begin errors++; $display("FAIL stream_samples got %0d want 200", d); end
  endtask

  task automatic test_underrun();
    int w, x, bp, bt, bu;
    logic [31:0] d;
    apply_reset(); flush_fifo();
    reg_write(3'd1, 32'd8);
    push(32'h00AB_CDEF);
    bp = n_pop; bt = n_txv; bu = n_und; w = cyc;
    reg_write(3'd0, 32'd1);
    wait_cyc(w + 14);
    reg_write(3'd0, 32'd0);
    wait_cyc(w + 20);
    checks++; if (n_pop - bp !== 0) begin errors++; $display("FAIL und_pops got %0d want 0", n_pop - bp); end
    checks++; if (n_und - bu !== 1) begin errors++; $display("FAIL und_pulses got %0d want 1", n_und - bu); end
    checks++; if (und_cyc[bu] !== w + 9) begin errors++; $display("FAIL und_cyc got %0d want %0d", und_cyc[bu], w + 9); end
    checks++; if (n_txv - bt !== 1) begin errors++; $display("FAIL und_txv_count got %0d want 1", n_txv - bt); end
    checks++; if (txv_cyc[bt] !== w + 13) begin errors++; $display("FAIL und_txv_cyc got %0d want %0d", txv_cyc[bt], w + 13); end
    checks++; if ({txv_i[bt], txv_q[bt]} !== 32'd0) begin errors++; $display("FAIL und_samples_zero got %h %h want 0 0", txv_i[bt], txv_q[bt]); end
    checks++; if (fifo_level !== 11'd1) begin errors++; $display("FAIL und_level got %0d want 1", fifo_level); end
    reg_read(3'd2, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL und_count got %0d want 1", d); end
    reg_read(3'd3, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL und_samples_reg got %0d want 0", d); end
    x = cyc;
    reg_write(3'd0, 32'd3);
    reg_read(3'd2, d);
    reg_write(3'd0, 32'd0);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL und_clear got %0d want 0", d); end
    flush_fifo();
    // clear written in the very cycle the underrun increment happens
    bu = n_und; w = cyc;
    reg_write(3'd0, 32'd1);
    wait_cyc(w + 8);
    reg_write(3'd0, 32'd3);
    reg_write(3'd0, 32'd0);
    wait_cyc(w + 20);
    checks++; if (n_und - bu !== 1) begin errors++; $display("FAIL und_coinc_pulse got %0d want 1", n_und - bu); end
    reg_read(3'd2, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL und_coinc_count got %0d want 0", d); end
    if (x < 0) $display("x %0d", x);
  endtask

  task automatic test_disable_mid_pair();
    int w, bp, bt, bu;
    logic [31:0] d;
    apply_reset(); flush_fifo();
    reg_write(3'd1, 32'd8);
    push(32'h0055_6600); push(32'h0077_8800); push(32'h0099_AA00); push(32'h00BB_CC00);
    bp = n_pop; bt = n_txv; bu = n_und; w = cyc;
    reg_write(3'd0, 32'd1);
    wait_cyc(w + 9);
    reg_write(3'd0, 32'd0);
    wait_cyc(w + 40);
    checks++; if (n_pop - bp !== 2) begin errors++; $display("FAIL dis_pops got %0d want 2", n_pop - bp); end
    checks++; if (n_txv - bt !== 1) begin errors++; $display("FAIL dis_txv_count got %0d want 1", n_txv - bt); end
    checks++; if (txv_cyc[bt] !== w + 13) begin errors++; $display("FAIL dis_txv_cyc got %0d want %0d", txv_cyc[bt], w + 13); end
    checks++; if ({txv_i[bt], txv_q[bt]} !== 32'h5566_7788) begin errors++; $display("FAIL dis_values got %h %h want 5566 7788", txv_i[bt], txv_q[bt]); end
    checks++; if (n_und - bu !== 0) begin errors++; $display("FAIL dis_underruns got %0d want 0", n_und - bu); end
    checks++; if (fifo_level !== 11'd2) begin errors++; $display("FAIL dis_level got %0d want 2", fifo_level); end
    reg_read(3'd4, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL dis_status got %0d want 0", d); end
    flush_fifo();
  endtask

  task automatic test_register_edges();
    int w, bt, bu;
    logic [31:0] d;
    apply_reset(); flush_fifo();
    reg_read(3'd1, d);
    checks++; if (d !== 32'd640) begin errors++; $display("FAIL reg_period_reset got %0d want 640", d); end
    reg_write(3'd1, 32'd3);
    reg_read(3'd1, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL reg_period_readback got %0d want 3", d); end
    bt = n_txv; bu = n_und; w = cyc;
    reg_write(3'd0, 32'd1);
    wait_cyc(w + 22);
    reg_write(3'd0, 32'd0);
    wait_cyc(w + 40);
    checks++; if (n_txv - bt !== 2) begin errors++; $display("FAIL reg_min_txv_count got %0d want 2", n_txv - bt); end
    checks++; if (txv_cyc[bt] !== w + 13) begin errors++; $display("FAIL reg_min_txv0 got %0d want %0d", txv_cyc[bt], w + 13); end
    checks++; if (txv_cyc[bt+1] !== w + 21) begin errors++; $display("FAIL reg_min_txv1 got %0d want %0d", txv_cyc[bt+1], w + 21); end
    checks++; if (n_und - bu !== 2) begin errors++; $display("FAIL reg_min_und got %0d want 2", n_und - bu); end
    for (int a = 5; a < 8; a++) begin
      reg_read(3'd1, d);
      reg_read(3'(a), d);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL reg_addr%0d got %h want 0", a, d); end
    end
    reg_write(3'd5, 32'hFFFF_FFFF);
    reg_write(3'd7, 32'hFFFF_FFFF);
    reg_read(3'd1, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL reg_ignored_wr_period got %0d want 3", d); end
    reg_read(3'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reg_ignored_wr_ctrl got %h want 0", d); end
  endtask

  task automatic test_async_reset();
    int w, bp, bt;
    logic [31:0] d;
    apply_reset(); flush_fifo();
    reg_write(3'd1, 32'd8);
    push(32'h0011_1100); push(32'h0022_2200); push(32'h0033_3300); push(32'h0044_4400);
    bp = n_pop; bt = n_txv; w = cyc;
    reg_write(3'd0, 32'd1);
    wait_cyc(w + 14);
    reg_read(3'd1, d);
    checks++; if (tx_i !== 16'h1111) begin errors++; $display("FAIL arst_pre_tx_i got %h want 1111", tx_i); end
    wait_cyc(w + 18);
    checks++; if (fifo_read !== 1'b1) begin errors++; $display("FAIL arst_pre_pop got %b want 1", fifo_read); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({fifo_read, tx_valid, underrun} !== 3'b000) begin
      errors++; $display("FAIL arst_strobes got %b want 000", {fifo_read, tx_valid, underrun});
    end
    checks++;
    if ({tx_i, tx_q, ctl_readdata} !== 64'd0) begin
      errors++; $display("FAIL arst_data got %h %h %h want 0", tx_i, tx_q, ctl_readdata);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (n_pop - bp !== 4) begin errors++; $display("FAIL arst_pops got %0d want 4", n_pop - bp); end
    checks++; if (n_txv - bt !== 1) begin errors++; $display("FAIL arst_txv got %0d want 1", n_txv - bt); end
    reg_read(3'd1, d);
    checks++; if (d !== 32'd640) begin errors++; $display("FAIL arst_period got %0d want 640", d); end
    reg_read(3'd4, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL arst_status got %0d want 0", d); end
    reg_read(3'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL arst_ctrl got %h want 0", d); end
    flush_fifo();
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_streaming();
    test_underrun();
    test_disable_mid_pair();
    test_register_edges();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
